// File: rtl/g5_apblink_slave_if.sv
// Bundle for the APBLink slave: serial link lanes from the master plus the local APB4 bus.
// The slave modport is the g5_apblink_slave view; master is the opposite side (link master + APB target).
interface g5_apblink_slave_if;
  logic        lnk_s_enable;
  logic [2:0]  lnk_s_addr;
  logic [3:0]  lnk_s_wdata;
  logic [3:0]  lnk_s_rdata;
  logic [25:0] m_paddr;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [3:0]  m_pstrb;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  modport slave (
    input  lnk_s_enable, lnk_s_addr, lnk_s_wdata, m_prdata, m_pready, m_pslverr,
    output lnk_s_rdata, m_paddr, m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata
  );

  modport master (
    output lnk_s_enable, lnk_s_addr, lnk_s_wdata, m_prdata, m_pready, m_pslverr,
    input  lnk_s_rdata, m_paddr, m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata
  );
endinterface

// File: rtl/g5_apblink_slave.sv
// G5 APBLink far end: deserialises command/address/data lanes, runs one APB4 transfer,
// and serialises the completion marker and read data back on the return lane.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command on lnk_s_addr[1:0]
// S_AD    | AD0..AD7, one address/write-data bit slice per cycle (idx_q)
// S_STUP  | latch byte strobes from lnk_s_wdata
// S_SETUP | APB setup phase (psel=1, penable=0)
// S_ACCS  | APB access phase, waiting for pready or timeout
// S_RSP   | one-cycle ready/error marker on lnk_s_rdata
// S_RD    | RD0..RD7, one read-data nibble per cycle (idx_q)
module g5_apblink_slave #(
  parameter int TIMEOUT = 0
) (
  input logic                pclk,
  input logic                preset_b,
  g5_apblink_slave_if.slave  lnk
);

  typedef enum logic [2:0] {
    S_IDLE, S_AD, S_STUP, S_SETUP, S_ACCS, S_RSP, S_RD
  } state_t;

  localparam logic [15:0] TMO_LOAD = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;
  logic [15:0] tmo_q, tmo_d;

  always_ff @(posedge pclk or negedge preset_b) begin
    if (!preset_b) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      addr_q    <= 24'd0;
      pwdata_q  <= 32'd0;
      pstrb_q   <= 4'd0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 32'd0;
      tmo_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    err_d     = err_q;
    rd_d      = rd_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
        unique case (lnk.lnk_s_addr[1:0])
          2'b01, 2'b10: begin
            state_d  = S_AD;
            pwrite_d = lnk.lnk_s_addr[1];
          end
          2'b11: begin
            state_d  = S_STUP;
            pwrite_d = 1'b0;
          end
          default: ;
        endcase
      end
      S_AD: begin
        addr_d[{2'd0, idx_q}]   = lnk.lnk_s_addr[0];
        addr_d[{2'd1, idx_q}]   = lnk.lnk_s_addr[1];
        addr_d[{2'd2, idx_q}]   = lnk.lnk_s_addr[2];
        pwdata_d[{2'd0, idx_q}] = lnk.lnk_s_wdata[0];
        pwdata_d[{2'd1, idx_q}] = lnk.lnk_s_wdata[1];
        pwdata_d[{2'd2, idx_q}] = lnk.lnk_s_wdata[2];
        pwdata_d[{2'd3, idx_q}] = lnk.lnk_s_wdata[3];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_STUP;
      end
      S_STUP: begin
        pstrb_d = pwrite_q ? lnk.lnk_s_wdata : 4'h0;
        psel_d  = 1'b1;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        penable_d = 1'b1;
        tmo_d     = TMO_LOAD;
        state_d   = S_ACCS;
      end
      S_ACCS: begin
        // A pready arriving on the terminal-count cycle still completes normally.
        if (lnk.m_pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rd_d      = lnk.m_prdata;
          err_d     = lnk.m_pslverr;
          state_d   = S_RSP;
        end else if (TIMEOUT > 0) begin
          if (tmo_q == 16'd0) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            rd_d      = 32'd0;
            err_d     = 1'b1;
            state_d   = S_RSP;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
      end
      S_RSP: begin
        idx_d   = 3'd0;
        state_d = pwrite_q ? S_IDLE : S_RD;
      end
      S_RD: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!lnk.lnk_s_enable) begin
      state_d   = S_IDLE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  always_comb begin
    lnk.lnk_s_rdata = 4'h0;
    if (state_q == S_RSP) begin
      lnk.lnk_s_rdata = {err_q, 3'b100};
    end else if (state_q == S_RD) begin
      lnk.lnk_s_rdata = {rd_q[{2'd3, idx_q}], rd_q[{2'd2, idx_q}],
                         rd_q[{2'd1, idx_q}], rd_q[{2'd0, idx_q}]};
    end
  end

  assign lnk.m_paddr   = {addr_q, 2'b00};
  assign lnk.m_psel    = psel_q;
  assign lnk.m_penable = penable_q;
  assign lnk.m_pwrite  = pwrite_q;
  assign lnk.m_pstrb   = pstrb_q;
  assign lnk.m_pwdata  = pwdata_q;

endmodule

// File: tb/tb_g5_apblink_slave.sv
// Directed bench for g5_apblink_slave: plays the link master and a simple APB target,
// stepping one cycle at a time and checking outputs 1 time unit after each rising edge.
module tb_g5_apblink_slave;
  logic pclk = 1'b0;
  logic preset_b = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  g5_apblink_slave_if bus ();

  g5_apblink_slave #(.TIMEOUT(16)) dut (
    .pclk     (pclk),
    .preset_b (preset_b),
    .lnk      (bus)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Nibbles {n7..n0} the return lane should carry for a 32-bit read word.
  function automatic logic [31:0] nibs(input logic [31:0] d);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = {d[24+i], d[16+i], d[8+i], d[i]};
    return r;
  endfunction

  // Presents cmd at an IDLE edge, then n_ad address/data slices; leaves lanes at NOOP.
  task automatic send_cmd(input logic [1:0] cmd, input logic [25:0] paddr,
                          input logic [31:0] wd, input int n_ad);
    logic [23:0] a;
    a = paddr[25:2];
    bus.lnk_s_addr = {1'b0, cmd};
    bus.lnk_s_wdata = 4'h0;
    step();
    for (int i = 0; i < n_ad; i++) begin
      bus.lnk_s_addr  = {a[16+i], a[8+i], a[i]};
      bus.lnk_s_wdata = {wd[24+i], wd[16+i], wd[8+i], wd[i]};
      step();
    end
    bus.lnk_s_addr  = 3'b000;
    bus.lnk_s_wdata = 4'h0;
  endtask

  // From STUP: present strobes, go through SETUP and check the APB request there.
  task automatic setup_phase(input logic [3:0] strb, input logic [25:0] exp_addr,
                             input logic [31:0] exp_wd, input logic exp_wr,
                             input logic [3:0] exp_strb);
    bus.lnk_s_wdata = strb;
    step();
    bus.lnk_s_wdata = 4'h0;
    chk("setup_psel", bus.m_psel, 1);
    chk("setup_penable", bus.m_penable, 0);
    chk("setup_paddr", bus.m_paddr, exp_addr);
    chk("setup_pwrite", bus.m_pwrite, exp_wr);
    chk("setup_pstrb", bus.m_pstrb, exp_strb);
    if (exp_wr) chk("setup_pwdata", bus.m_pwdata, exp_wd);
    step();
    chk("accs_penable", bus.m_penable, 1);
  endtask

  // In ACCS: hold pready low for waits cycles, then complete; ends in RSP and checks the marker.
  task automatic complete(input int waits, input logic [31:0] prd, input logic err,
                          input logic [3:0] exp_rsp);
    for (int i = 0; i < waits; i++) begin
      chk("wait_no_marker", bus.lnk_s_rdata, 0);
      step();
    end
    bus.m_pready  = 1'b1;
    bus.m_prdata  = prd;
    bus.m_pslverr = err;
    step();
    bus.m_pready  = 1'b0;
    bus.m_pslverr = 1'b0;
    chk("rsp_marker", bus.lnk_s_rdata, exp_rsp);
    chk("rsp_psel_low", bus.m_psel, 0);
  endtask

  task automatic read_out(input logic [31:0] exp_nibs);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rd_nibble%0d", i), bus.lnk_s_rdata, exp_nibs[4*i +: 4]);
    end
    step();
    chk("idle_rdata_zero", bus.lnk_s_rdata, 0);
  endtask

  initial begin
    bus.lnk_s_enable = 1'b1;
    bus.lnk_s_addr   = 3'b000;
    bus.lnk_s_wdata  = 4'h0;
    bus.m_prdata     = 32'h0;
    bus.m_pready     = 1'b0;
    bus.m_pslverr    = 1'b0;

    #12;
    chk("rst_psel", bus.m_psel, 0);
    chk("rst_paddr", bus.m_paddr, 0);
    chk("rst_pwdata", bus.m_pwdata, 0);
    chk("rst_pstrb", bus.m_pstrb, 0);
    chk("rst_rdata", bus.lnk_s_rdata, 0);
    preset_b = 1'b1;
    step();

    // Zero-wait write
    send_cmd(2'b10, 26'h0ABCDE4, 32'h1234_5678, 8);
    chk("stup_psel_low", bus.m_psel, 0);
    setup_phase(4'hF, 26'h0ABCDE4, 32'h1234_5678, 1'b1, 4'hF);
    complete(0, 32'h0, 1'b0, 4'h4);
    step();
    chk("wr_idle_rdata", bus.lnk_s_rdata, 0);

    // Read with 3 wait states, issued straight from the IDLE cycle after the write
    send_cmd(2'b01, 26'h0000100, 32'h0, 8);
    setup_phase(4'hF, 26'h0000100, 32'h0, 1'b0, 4'h0);
    complete(3, 32'hA5C3_0F81, 1'b0, 4'h4);
    read_out(32'hD480_2A6F);

    // POLL re-reads the held address; bit 2 of the command lane is ignored
    bus.lnk_s_addr = 3'b111;
    step();
    bus.lnk_s_addr = 3'b000;
    setup_phase(4'hF, 26'h0000100, 32'h0, 1'b0, 4'h0);
    complete(0, 32'h0000_0003, 1'b0, 4'h4);
    read_out(32'h0000_0011);

    // Slave error on write, then on read
    send_cmd(2'b10, 26'h1555554, 32'hCAFE_0001, 8);
    setup_phase(4'h3, 26'h1555554, 32'hCAFE_0001, 1'b1, 4'h3);
    complete(1, 32'h0, 1'b1, 4'hC);
    step();
    chk("wr_err_idle", bus.lnk_s_rdata, 0);
    send_cmd(2'b01, 26'h2000008, 32'h0, 8);
    setup_phase(4'h0, 26'h2000008, 32'h0, 1'b0, 4'h0);
    complete(0, 32'h0000_00FF, 1'b1, 4'hC);
    read_out(nibs(32'h0000_00FF));

    // Timeout: pready never comes, abort on the 16th access cycle
    send_cmd(2'b01, 26'h0000200, 32'h0, 8);
    setup_phase(4'h0, 26'h0000200, 32'h0, 1'b0, 4'h0);
    bus.m_prdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_cycle16_penable", bus.m_penable, 1);
    chk("tmo_cycle16_marker", bus.lnk_s_rdata, 0);
    step();
    chk("tmo_rsp", bus.lnk_s_rdata, 4'hC);
    chk("tmo_psel", bus.m_psel, 0);
    read_out(32'h0);

    // Async reset during AD4
    send_cmd(2'b10, 26'h0ABCDE4, 32'h1234_5678, 4);
    preset_b = 1'b0;
    #1;
    chk("midrst_paddr", bus.m_paddr, 0);
    chk("midrst_pwdata", bus.m_pwdata, 0);
    chk("midrst_pwrite", bus.m_pwrite, 0);
    chk("midrst_psel", bus.m_psel, 0);
    chk("midrst_rdata", bus.lnk_s_rdata, 0);
    preset_b = 1'b1;
    step();
    bus.lnk_s_addr = 3'b011;
    step();
    bus.lnk_s_addr = 3'b000;
    setup_phase(4'hF, 26'h0, 32'h0, 1'b0, 4'h0);
    complete(0, 32'h8000_0000, 1'b0, 4'h4);
    read_out(nibs(32'h8000_0000));

    // Enable dropped during access abandons the APB cycle
    send_cmd(2'b01, 26'h0000300, 32'h0, 8);
    setup_phase(4'h0, 26'h0000300, 32'h0, 1'b0, 4'h0);
    bus.lnk_s_enable = 1'b0;
    step();
    chk("en_drop_psel", bus.m_psel, 0);
    chk("en_drop_penable", bus.m_penable, 0);
    chk("en_drop_rdata", bus.lnk_s_rdata, 0);
    bus.lnk_s_enable = 1'b1;
    send_cmd(2'b10, 26'h3FFFFFC, 32'hDEAD_BEEF, 8);
    setup_phase(4'h5, 26'h3FFFFFC, 32'hDEAD_BEEF, 1'b1, 4'h5);
    complete(0, 32'h0, 1'b0, 4'h4);
    step();
    chk("final_idle_rdata", bus.lnk_s_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end
endmodule
